// File: rtl/pds_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pds_port_arbiter
// Purpose  : Round-robin arbiter that shares the single PDS input port
//            (data_ip / valid_up) among NPORTS packet requesters. Each
//            requester owns a one-entry holding register. One packet is
//            issued at a time, held until the DUT accepts it, and each
//            accepted packet is followed by GAP idle cycles.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous, active-high reset
//            req_valid  - per-port packet valid
//            req_data   - per-port packet, port i at [i*PKT_W +: PKT_W]
//            req_ready  - per-port holding register empty
//            data_ip    - registered packet to the DUT
//            valid_up   - registered packet valid to the DUT
//            dut_ready  - DUT accepts data_ip when valid_up && dut_ready
//            grant_id   - port index of the packet currently on data_ip
//            busy       - not idle, or any holding register full
//            pkt_count  - packets accepted by the DUT (wraps)
// Options  : PDS_SRC_STAMP_EN - when defined, the granted port index
//            overwrites the source field data_ip[15:12] on grant.
// Revision : 1.0 - initial release
// ============================================================================
module pds_port_arbiter #(
    parameter int NPORTS = 4,
    parameter int PKT_W  = 16,
    parameter int GAP    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NPORTS-1:0]         req_valid,
    input  logic [NPORTS*PKT_W-1:0]   req_data,
    output logic [NPORTS-1:0]         req_ready,
    output logic [PKT_W-1:0]          data_ip,
    output logic                      valid_up,
    input  logic                      dut_ready,
    output logic [$clog2(NPORTS)-1:0] grant_id,
    output logic                      busy,
    output logic [15:0]               pkt_count
);

    localparam int               C_IDW  = $clog2(NPORTS);
    localparam logic [3:0]       C_GAP  = 4'(GAP);
    localparam logic [C_IDW-1:0] C_LAST = C_IDW'(NPORTS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NPORTS-1:0]  hold_v_q, hold_v_d;
    logic [PKT_W-1:0]   hold_q [NPORTS];
    logic [PKT_W-1:0]   hold_d [NPORTS];
    logic [PKT_W-1:0]   data_ip_q, data_ip_d;
    logic               valid_up_q, valid_up_d;
    logic [C_IDW-1:0]   grant_id_q, grant_id_d;
    logic [C_IDW-1:0]   ptr_q, ptr_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic [15:0]        pkt_count_q, pkt_count_d;

    logic               grant_found;
    logic [C_IDW-1:0]   grant_idx;
    logic [PKT_W-1:0]   grant_pkt;
    logic [C_IDW:0]     cand;

    // Rotating priority search: first full holding register at or after
    // ptr_q, wrapping modulo NPORTS. One extra bit in cand absorbs the
    // overflow before the wrap is subtracted away.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NPORTS; k++) begin
            cand = {1'b0, ptr_q} + (C_IDW + 1)'(k);
            if (cand >= (C_IDW + 1)'(NPORTS)) begin
                cand = cand - (C_IDW + 1)'(NPORTS);
            end
            if (!grant_found && hold_v_q[cand[C_IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[C_IDW-1:0];
            end
        end
    end

`ifdef PDS_SRC_STAMP_EN
    always_comb begin
        grant_pkt                = hold_q[grant_idx];
        grant_pkt[PKT_W-1 -: 4] = 4'(grant_idx);
    end
`else
    assign grant_pkt = hold_q[grant_idx];
`endif

    always_comb begin
        state_d     = state_q;
        hold_v_d    = hold_v_q;
        hold_d      = hold_q;
        data_ip_d   = data_ip_q;
        valid_up_d  = valid_up_q;
        grant_id_d  = grant_id_q;
        ptr_d       = ptr_q;
        gap_cnt_d   = gap_cnt_q;
        pkt_count_d = pkt_count_q;

        // Capture into empty holding registers. A port being granted this
        // edge is full, so capture and grant never collide on one port.
        for (int i = 0; i < NPORTS; i++) begin
            if (req_valid[i] && !hold_v_q[i]) begin
                hold_v_d[i] = 1'b1;
                hold_d[i]   = req_data[i*PKT_W +: PKT_W];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    data_ip_d           = grant_pkt;
                    valid_up_d          = 1'b1;
                    grant_id_d          = grant_idx;
                    hold_v_d[grant_idx] = 1'b0;
                    state_d             = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (dut_ready) begin
                    valid_up_d  = 1'b0;
                    pkt_count_d = pkt_count_q + 16'd1;
                    ptr_d       = (grant_id_q == C_LAST) ? '0 : grant_id_q + 1'b1;
                    if (GAP > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = C_GAP;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                // The counter holds the number of gap cycles still owed,
                // including the current one.
                if (gap_cnt_q <= 4'd1) begin
                    state_d   = S_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_v_q    <= '0;
            for (int i = 0; i < NPORTS; i++) begin
                hold_q[i] <= '0;
            end
            data_ip_q   <= '0;
            valid_up_q  <= 1'b0;
            grant_id_q  <= '0;
            ptr_q       <= '0;
            gap_cnt_q   <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_v_q    <= hold_v_d;
            hold_q      <= hold_d;
            data_ip_q   <= data_ip_d;
            valid_up_q  <= valid_up_d;
            grant_id_q  <= grant_id_d;
            ptr_q       <= ptr_d;
            gap_cnt_q   <= gap_cnt_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign req_ready = ~hold_v_q;
    assign data_ip   = data_ip_q;
    assign valid_up  = valid_up_q;
    assign grant_id  = grant_id_q;
    assign pkt_count = pkt_count_q;
    assign busy      = (state_q != S_IDLE) || (|hold_v_q);

endmodule
`default_nettype wire

// File: tb/tb_pds_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pds_port_arbiter
// Purpose  : Self-checking bench for pds_port_arbiter (NPORTS=4, GAP=1).
//            Directed table of vectors, hand-written corner sequences, and
//            randomized traffic compared against a transaction-style model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pds_port_arbiter;

    localparam int NP    = 4;
    localparam int GAP_T = 1;

    logic          clk;
    logic          reset;
    logic [NP-1:0] req_valid;
    logic [NP*16-1:0] req_data;
    logic [NP-1:0] req_ready;
    logic [15:0]   data_ip;
    logic          valid_up;
    logic          dut_ready;
    logic [1:0]    grant_id;
    logic          busy;
    logic [15:0]   pkt_count;

    int total = 0;
    int bad   = 0;

    pds_port_arbiter #(.NPORTS(NP), .PKT_W(16), .GAP(GAP_T)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .data_ip   (data_ip),
        .valid_up  (valid_up),
        .dut_ready (dut_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Packets wait in per-port slots; one packet is "on the wire" at a time;
    // after each acceptance the next grant is delayed by GAP_T edges.
    bit          m_occ  [NP];
    logic [15:0] m_hold [NP];
    bit          m_wire;
    int          m_port;
    logic [15:0] m_data;
    int          m_wait;
    int          m_ptr;
    int          m_cnt;
    int          dut_q[$];

    function automatic logic [15:0] stamp(input logic [15:0] p, input int port);
`ifdef PDS_SRC_STAMP_EN
        return {port[3:0], p[11:0]};
`else
        return p;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_occ[i]  = 0;
            m_hold[i] = '0;
        end
        m_wire = 0; m_port = 0; m_data = '0;
        m_wait = 0; m_ptr = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit pre[NP];
        bit done;
        for (int i = 0; i < NP; i++) pre[i] = m_occ[i];
        if (m_wire) begin
            if (dut_ready) begin
                m_wire = 0;
                m_cnt  = (m_cnt + 1) % 65536;
                m_ptr  = (m_port + 1) % NP;
                m_wait = GAP_T;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else begin
            done = 0;
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (m_ptr + k) % NP;
                if (!done && pre[p]) begin
                    done     = 1;
                    m_wire   = 1;
                    m_port   = p;
                    m_data   = stamp(m_hold[p], p);
                    m_occ[p] = 0;
                end
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (req_valid[i] && !pre[i]) begin
                m_occ[i]  = 1;
                m_hold[i] = req_data[i*16 +: 16];
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [NP-1:0] rdy;
        bit any;
        any = 0;
        for (int i = 0; i < NP; i++) begin
            rdy[i] = !m_occ[i];
            if (m_occ[i]) any = 1;
        end
        check("m_req_ready", 32'(req_ready), 32'(rdy));
        check("m_valid_up",  32'(valid_up),  32'(m_wire));
        check("m_data_ip",   32'(data_ip),   32'(m_data));
        check("m_grant_id",  32'(grant_id),  32'(m_port));
        check("m_pkt_count", 32'(pkt_count), 32'(m_cnt));
        check("m_busy",      32'(busy),      32'(m_wire || m_wait > 0 || any));
    endtask

    // One clock: drive, model at the edge, compare at the falling edge.
    task automatic cycle(input logic [3:0] rv, input logic dr);
        req_valid = rv;
        dut_ready = dr;
        if (valid_up && dr) dut_q.push_back(int'(grant_id));
        @(posedge clk);
        model_step();
        @(negedge clk);
        model_check();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        dut_ready = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic set_port(input int i, input logic [15:0] d);
        req_data[i*16 +: 16] = d;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0]  rv;
        logic        dr;
        logic        exp_v;
        logic [15:0] exp_d;
        logic [1:0]  exp_g;
        logic [3:0]  exp_rdy;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0; dut_ready = 1'b0;
        model_reset();

        // All four ports loaded together: issue 0,1,2,3 three cycles apart.
        tbl[0]  = '{4'hF, 1'b1, 1'b0, 16'h0000, 2'd0, 4'h0, 16'd0};
        tbl[1]  = '{4'h0, 1'b1, 1'b1, 16'h0011, 2'd0, 4'h1, 16'd0};
        tbl[2]  = '{4'h0, 1'b1, 1'b0, 16'h0011, 2'd0, 4'h1, 16'd1};
        tbl[3]  = '{4'h0, 1'b1, 1'b0, 16'h0011, 2'd0, 4'h1, 16'd1};
        tbl[4]  = '{4'h0, 1'b1, 1'b1, 16'h1122, 2'd1, 4'h3, 16'd1};
        tbl[5]  = '{4'h0, 1'b1, 1'b0, 16'h1122, 2'd1, 4'h3, 16'd2};
        tbl[6]  = '{4'h0, 1'b1, 1'b0, 16'h1122, 2'd1, 4'h3, 16'd2};
        tbl[7]  = '{4'h0, 1'b1, 1'b1, 16'h2233, 2'd2, 4'h7, 16'd2};
        tbl[8]  = '{4'h0, 1'b1, 1'b0, 16'h2233, 2'd2, 4'h7, 16'd3};
        tbl[9]  = '{4'h0, 1'b1, 1'b0, 16'h2233, 2'd2, 4'h7, 16'd3};
        tbl[10] = '{4'h0, 1'b1, 1'b1, 16'h3344, 2'd3, 4'hF, 16'd3};
        tbl[11] = '{4'h0, 1'b1, 1'b0, 16'h3344, 2'd3, 4'hF, 16'd4};

        // Reset state
        do_reset();
        check("rst_req_ready", 32'(req_ready), 32'hF);
        check("rst_valid_up",  32'(valid_up),  32'h0);
        check("rst_data_ip",   32'(data_ip),   32'h0);
        check("rst_pkt_count", 32'(pkt_count), 32'h0);
        check("rst_grant_id",  32'(grant_id),  32'h0);
        check("rst_busy",      32'(busy),      32'h0);

        // Table
        req_data = {16'h3344, 16'h2233, 16'h1122, 16'h0011};
        for (int s = 0; s < 12; s++) begin
            cycle(tbl[s].rv, tbl[s].dr);
            check($sformatf("tbl%0d_valid", s), 32'(valid_up),  32'(tbl[s].exp_v));
            check($sformatf("tbl%0d_data", s),  32'(data_ip),   32'(tbl[s].exp_d));
            check($sformatf("tbl%0d_gid", s),   32'(grant_id),  32'(tbl[s].exp_g));
            check($sformatf("tbl%0d_ready", s), 32'(req_ready), 32'(tbl[s].exp_rdy));
            check($sformatf("tbl%0d_cnt", s),   32'(pkt_count), 32'(tbl[s].exp_cnt));
        end

        // Single packet on port 2
        do_reset();
        set_port(2, 16'h2A55);
        cycle(4'b0100, 1'b1);
        check("single_capture_valid", 32'(valid_up), 32'h0);
        cycle(4'b0000, 1'b1);
        check("single_valid", 32'(valid_up), 32'h1);
        check("single_data",  32'(data_ip),  32'h2A55);
        check("single_gid",   32'(grant_id), 32'h2);
        cycle(4'b0000, 1'b1);
        check("single_drop",  32'(valid_up),  32'h0);
        check("single_cnt",   32'(pkt_count), 32'h1);
        check("single_keep",  32'(data_ip),   32'h2A55);

        // Backpressure with refill of port 0 during the stall
        do_reset();
        set_port(0, 16'h0BC1);
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);
        for (int s = 0; s < 5; s++) begin
            if (s == 1) set_port(0, 16'h0777);
            cycle((s == 1) ? 4'b0001 : 4'b0000, 1'b0);
            check("bp_valid", 32'(valid_up), 32'h1);
            check("bp_data",  32'(data_ip),  32'h0BC1);
            check("bp_gid",   32'(grant_id), 32'h0);
        end
        check("bp_refilled", 32'(req_ready[0]), 32'h0);
        cycle(4'b0000, 1'b1);
        check("bp_xfer_valid", 32'(valid_up),  32'h0);
        check("bp_xfer_cnt",   32'(pkt_count), 32'h1);

        // Fairness: ports 1 and 3 continuously requesting
        do_reset();
        dut_q.delete();
        begin
            int n;
            n = 0;
            while (dut_q.size() < 20 && n < 300) begin
                set_port(1, 16'(($urandom & 16'h0FFF) | 16'h1000));
                set_port(3, 16'(($urandom & 16'h0FFF) | 16'h3000));
                cycle(4'b1010, 1'b1);
                n++;
            end
        end
        check("fair_grants", 32'(dut_q.size()), 32'd20);
        for (int k = 0; k < dut_q.size(); k++) begin
            check($sformatf("fair_order%0d", k), 32'(dut_q[k]), (k % 2 == 0) ? 32'd1 : 32'd3);
        end
        check("fair_cnt", 32'(pkt_count), 32'd20);

        // Reset while in ISSUE, pointer returns to 0
        do_reset();
        set_port(1, 16'h1A00);
        cycle(4'b0010, 1'b1);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        set_port(1, 16'h1A01);
        set_port(3, 16'h3A03);
        cycle(4'b1010, 1'b0);
        cycle(4'b0000, 1'b0);
        check("rstiss_pre_gid",   32'(grant_id), 32'h3);
        check("rstiss_pre_valid", 32'(valid_up), 32'h1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("rstiss_async_valid", 32'(valid_up),  32'h0);
        check("rstiss_async_ready", 32'(req_ready), 32'hF);
        check("rstiss_async_cnt",   32'(pkt_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        cycle(4'b1010, 1'b0);
        cycle(4'b0000, 1'b0);
        check("rstiss_post_gid", 32'(grant_id), 32'h1);

        // Source stamp option on port 3
        do_reset();
        set_port(3, 16'h0F12);
        cycle(4'b1000, 1'b1);
        cycle(4'b0000, 1'b1);
`ifdef PDS_SRC_STAMP_EN
        check("stamp_data", 32'(data_ip), 32'h3F12);
`else
        check("stamp_data", 32'(data_ip), 32'h0F12);
`endif
        check("stamp_gid", 32'(grant_id), 32'h3);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NP; i++) set_port(i, 16'($urandom));
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pds_port_arbiter.md
Name: pds_port_arbiter

Overview:
- Round-robin arbiter that shares the single PDS input port (data_ip/valid_up) among NPORTS packet requesters.
- Each requester gets a one-entry holding register.
- The arbiter issues one 16-bit packet ({source[3:0], target[3:0], data[7:0]}) at a time, holds it until the DUT accepts it, then inserts a programmable idle gap.
- Sits between the testbench/traffic sources and the PDS DUT input.

Parameters:
- NPORTS, 4, number of requesters (2..8)
- PKT_W, 16, packet width; field layout fixed as [15:12] source, [11:8] target, [7:0] data
- GAP, 1, idle cycles forced after each accepted packet (0..15)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NPORTS  per-port packet valid
- req_data  input  NPORTS*PKT_W  per-port packet; port i in bits [i*PKT_W +: PKT_W]
- req_ready  output  NPORTS  per-port holding register empty
- data_ip  output  PKT_W  packet to DUT, registered
- valid_up  output  1  packet valid to DUT, registered
- dut_ready  input  1  DUT accepts data_ip when valid_up && dut_ready
- grant_id  output  $clog2(NPORTS)  port index of the packet currently on data_ip
- busy  output  1  high when not in IDLE or any holding register is full
- pkt_count  output  16  count of packets accepted by the DUT; wraps 16'hFFFF -> 0

Behaviour:
- Reset is asynchronous and active-high. It forces:
  - all holding registers empty, so req_ready = all ones
  - data_ip = 0, valid_up = 0, grant_id = 0
  - pkt_count = 0, round-robin pointer = 0, state = IDLE
- Reset mid-packet drops the in-flight packet and all held packets; nothing is replayed.
- Capture:
  - req_ready[i] = !hold_v[i], combinational from the register.
  - On a clock edge with req_valid[i] && req_ready[i], store req_data[i] and set hold_v[i].
- FSM states: IDLE, ISSUE, GAP.
- IDLE:
  - If any hold_v is set, grant the first set index at or after ptr, searching upward and wrapping mod NPORTS.
  - On the grant edge:
    - data_ip <= hold[g], valid_up <= 1, grant_id <= g
    - hold_v[g] <= 0
    - state -> ISSUE
  - Port g shows req_ready = 1 in the following cycle and may refill then.
- ISSUE:
  - valid_up = 1, and data_ip and grant_id stay stable until transfer.
  - On an edge with dut_ready = 1:
    - valid_up <= 0, pkt_count++
    - ptr <= (grant_id + 1) mod NPORTS
    - state -> GAP if GAP > 0, else IDLE
  - With dut_ready = 0, hold indefinitely.
- GAP:
  - A down-counter is loaded with GAP on entry.
  - After exactly GAP cycles with valid_up = 0, return to IDLE.
- Timing:
  - Latency from the accepting edge of req_valid to valid_up asserted is 2 edges (capture, then grant).
  - Minimum spacing between consecutive valid_up rising edges, with dut_ready held at 1, is GAP + 2 cycles.
- Boundary conditions:
  - Simultaneous capture at port i and grant of a different port j is legal.
  - A port being granted cannot capture on the same edge, because its req_ready was 0.
  - All ports full: each port is serviced exactly once per round, in pointer order.
  - A single active port is granted back-to-back; the pointer still advances past it.
  - dut_ready high while valid_up = 0 is ignored.
  - data_ip keeps its last value after transfer; it is not cleared.

Optional Feature:
- Macro PDS_SRC_STAMP_EN.
- Defined: on grant, data_ip[15:12] <= grant index (zero-extended to 4 bits), overwriting the requester's source field. Bits [11:0] pass unchanged.
- Undefined: data_ip is loaded with the held packet unmodified.

Test Plan:
- Reset, then idle:
  - Expect req_ready = 4'hF, valid_up = 0, data_ip = 0, pkt_count = 0.
- Single packet, port 2, req_data = 16'h2A55, dut_ready = 1:
  - valid_up high exactly 1 cycle, starting 2 edges after capture.
  - data_ip = 16'h2A55, grant_id = 2, pkt_count = 1.
- All 4 ports loaded on the same edge with 16'h0011, 16'h1122, 16'h2233, 16'h3344, GAP = 1, dut_ready = 1:
  - Issue order is ports 0, 1, 2, 3.
  - valid_up pulses 3 cycles apart.
  - pkt_count = 4.
- Backpressure, dut_ready = 0 for 5 cycles while valid_up = 1:
  - data_ip and grant_id stable.
  - Port 0 refills during the stall.
  - Transfer occurs on the first dut_ready = 1 edge.
- Fairness, ports 1 and 3 refilled continuously for 20 grants:
  - Grants alternate 1, 3, 1, 3, ...
  - pkt_count = 20.
- Reset asserted in ISSUE:
  - valid_up drops to 0 immediately, without waiting for a clock edge.
  - After release, the next grant starts from port 0.
- With PDS_SRC_STAMP_EN, port 3 sends 16'h0F12:
  - data_ip = 16'h3F12.
